// File: rtl/btb_types_pkg.sv
// Shared types for the branch target buffer: counter encoding, FSM states
// and the stored entry layout (fields sized for PCs up to 64 bits).
package btb_types_pkg;

  localparam int BTB_FIELD_W = 64;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } btb_ctr_t;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } btb_state_t;

  typedef struct packed {
    logic                   valid;
    logic [BTB_FIELD_W-1:0] tag;
    logic [BTB_FIELD_W-1:0] target;
    btb_ctr_t               ctr;
  } btb_entry_t;

  localparam btb_entry_t BTB_ENTRY_EMPTY = '{valid: 1'b0, tag: '0, target: '0, ctr: SNT};

endpackage

// File: rtl/btb_sat_ctr.sv
// Two-bit saturating counter step: moves toward ST on taken, toward SNT on
// not-taken, holding at either end.
module btb_sat_ctr
  import btb_types_pkg::*;
(
  input  btb_ctr_t ctr_i,
  input  logic     taken_i,
  output btb_ctr_t ctr_o
);

  always_comb begin
    ctr_o = ctr_i;
    if (taken_i && (ctr_i != ST)) begin
      ctr_o = btb_ctr_t'(ctr_i + 2'd1);
    end else if (!taken_i && (ctr_i != SNT)) begin
      ctr_o = btb_ctr_t'(ctr_i - 2'd1);
    end
  end

endmodule

// File: rtl/btb_predictor.sv
// Direct-mapped branch target buffer with zero-latency lookup and an INIT sweep
// that clears one entry per cycle. Optional performance counters: BTB_STATS_EN.
module btb_predictor
  import btb_types_pkg::*;
#(
  parameter int INDEX_BITS = 4,
  parameter int PC_WIDTH   = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                lookup_valid,
  input  logic [PC_WIDTH-1:0] lookup_pc,
  output logic                BTB_found,
  output logic                predict_result,
  output logic [PC_WIDTH-1:0] predict_target,
  output logic                ready,
  input  logic                upd_valid,
  input  logic [PC_WIDTH-1:0] upd_pc,
  input  logic [PC_WIDTH-1:0] upd_target,
  input  logic                upd_taken,
  input  logic                upd_uncond,
  input  logic                upd_mispredict,
  output logic [31:0]         stat_lookups,
  output logic [31:0]         stat_hits,
  output logic [31:0]         stat_mispredicts
);

  localparam int ENTRIES = 1 << INDEX_BITS;

  btb_entry_t            table_q [ENTRIES];
  btb_state_t            state_q, state_d;
  logic [INDEX_BITS-1:0] idx_q, idx_d;

  logic [INDEX_BITS-1:0] lookupIdx, updIdx, wrIdx;
  btb_entry_t            lookupEntry, updEntry, wrEntry;
  logic                  updHit, wrEn;
  btb_ctr_t              ctrNext;
  logic                  unusedBits;

  assign ready       = (state_q == RUN);
  assign lookupIdx   = lookup_pc[INDEX_BITS+1:2];
  assign lookupEntry = table_q[lookupIdx];

  // Lookup reads the array directly, so a same-cycle update is not visible yet.
  assign BTB_found = lookup_valid & ready & ~rst & lookupEntry.valid &
                     (lookupEntry.tag == BTB_FIELD_W'(lookup_pc[PC_WIDTH-1:INDEX_BITS+2]));
  assign predict_result = BTB_found & lookupEntry.ctr[1];
  assign predict_target = PC_WIDTH'(lookupEntry.target);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      INIT: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == INDEX_BITS'(ENTRIES - 1)) begin
          state_d = RUN;
        end
      end
      RUN: begin
        state_d = RUN;
      end
      default: begin
        state_d = INIT;
      end
    endcase
  end

  assign updIdx   = upd_pc[INDEX_BITS+1:2];
  assign updEntry = table_q[updIdx];
  assign updHit   = updEntry.valid &
                    (updEntry.tag == BTB_FIELD_W'(upd_pc[PC_WIDTH-1:INDEX_BITS+2]));

  btb_sat_ctr u_sat_ctr (
    .ctr_i   (updEntry.ctr),
    .taken_i (upd_taken),
    .ctr_o   (ctrNext)
  );

  // The INIT sweep owns the single write port; resolved branches only write in RUN.
  always_comb begin
    wrEn    = 1'b0;
    wrIdx   = updIdx;
    wrEntry = updEntry;
    if (state_q == INIT) begin
      wrEn    = 1'b1;
      wrIdx   = idx_q;
      wrEntry = BTB_ENTRY_EMPTY;
    end else if (upd_valid) begin
      if (updHit) begin
        wrEn        = 1'b1;
        wrEntry.ctr = ctrNext;
        if (upd_taken) begin
          wrEntry.target = BTB_FIELD_W'(upd_target);
        end
      end else if (upd_taken) begin
        wrEn           = 1'b1;
        wrEntry.valid  = 1'b1;
        wrEntry.tag    = BTB_FIELD_W'(upd_pc[PC_WIDTH-1:INDEX_BITS+2]);
        wrEntry.target = BTB_FIELD_W'(upd_target);
        wrEntry.ctr    = upd_uncond ? ST : WT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wrEn) begin
      table_q[wrIdx] <= wrEntry;
    end
  end

`ifdef BTB_STATS_EN
  logic [31:0] lookupCnt_q, hitCnt_q, mispredCnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      lookupCnt_q  <= '0;
      hitCnt_q     <= '0;
      mispredCnt_q <= '0;
    end else begin
      if (lookup_valid && ready) lookupCnt_q <= lookupCnt_q + 32'd1;
      if (BTB_found) hitCnt_q <= hitCnt_q + 32'd1;
      if (upd_valid && upd_mispredict && ready) mispredCnt_q <= mispredCnt_q + 32'd1;
    end
  end

  assign stat_lookups     = lookupCnt_q;
  assign stat_hits        = hitCnt_q;
  assign stat_mispredicts = mispredCnt_q;
  assign unusedBits       = ^{lookup_pc[1:0], upd_pc[1:0]};
`else
  assign stat_lookups     = 32'd0;
  assign stat_hits        = 32'd0;
  assign stat_mispredicts = 32'd0;
  assign unusedBits       = ^{lookup_pc[1:0], upd_pc[1:0], upd_mispredict};
`endif

endmodule

// File: tb/tb_btb_predictor.sv
// Scoreboard-driven bench for btb_predictor: lookup expectations are queued when
// driven and popped when the outputs are sampled on the falling edge.
module tb_btb_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic        lookup_valid;
  logic [31:0] lookup_pc;
  logic        BTB_found;
  logic        predict_result;
  logic [31:0] predict_target;
  logic        ready;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [31:0] upd_target;
  logic        upd_taken;
  logic        upd_uncond;
  logic        upd_mispredict;
  logic [31:0] stat_lookups;
  logic [31:0] stat_hits;
  logic [31:0] stat_mispredicts;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        found;
    logic        pred;
    logic [31:0] target;
  } lkExp_t;

  lkExp_t sbQ[$];
  lkExp_t expL;

`ifdef BTB_STATS_EN
  localparam logic [31:0] EXP_LOOKUPS = 32'd4;
  localparam logic [31:0] EXP_HITS    = 32'd3;
  localparam logic [31:0] EXP_MISP    = 32'd1;
`else
  localparam logic [31:0] EXP_LOOKUPS = 32'd0;
  localparam logic [31:0] EXP_HITS    = 32'd0;
  localparam logic [31:0] EXP_MISP    = 32'd0;
`endif

  always #5 clk = ~clk;

  btb_predictor #(.INDEX_BITS(4), .PC_WIDTH(32)) dut (
    .clk              (clk),
    .rst              (rst),
    .lookup_valid     (lookup_valid),
    .lookup_pc        (lookup_pc),
    .BTB_found        (BTB_found),
    .predict_result   (predict_result),
    .predict_target   (predict_target),
    .ready            (ready),
    .upd_valid        (upd_valid),
    .upd_pc           (upd_pc),
    .upd_target       (upd_target),
    .upd_taken        (upd_taken),
    .upd_uncond       (upd_uncond),
    .upd_mispredict   (upd_mispredict),
    .stat_lookups     (stat_lookups),
    .stat_hits        (stat_hits),
    .stat_mispredicts (stat_mispredicts)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic driveUpdate(input logic [31:0] pc, input logic [31:0] tgt,
                             input logic taken, input logic uncond, input logic misp);
    upd_valid      = 1'b1;
    upd_pc         = pc;
    upd_target     = tgt;
    upd_taken      = taken;
    upd_uncond     = uncond;
    upd_mispredict = misp;
  endtask

  task automatic clearUpdate();
    upd_valid      = 1'b0;
    upd_taken      = 1'b0;
    upd_uncond     = 1'b0;
    upd_mispredict = 1'b0;
  endtask

  task automatic applyUpdate(input logic [31:0] pc, input logic [31:0] tgt,
                             input logic taken, input logic uncond, input logic misp);
    driveUpdate(pc, tgt, taken, uncond, misp);
    tick();
    clearUpdate();
  endtask

  task automatic pushLookup(input logic [31:0] pc, input logic f, input logic p,
                            input logic [31:0] t);
    lookup_valid = 1'b1;
    lookup_pc    = pc;
    sbQ.push_back('{found: f, pred: p, target: t});
  endtask

  task automatic test_reset();
    int cnt;
    int foundInInit;
    rst = 1'b1;
    pushLookup(32'h40, 1'b0, 1'b0, 32'h0);
    repeat (3) tick();
    @(negedge clk);
    expL = sbQ.pop_front();
    checks++;
    if (ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready: got %0b, expected 0", ready); end
    checks++;
    if (BTB_found !== expL.found) begin errors++; $display("[TB] FAIL reset_found: got %0b, expected %0b", BTB_found, expL.found); end
    checks++;
    if ({stat_lookups, stat_hits, stat_mispredicts} !== 96'd0) begin
      errors++;
      $display("[TB] FAIL reset_stats: got %0h/%0h/%0h, expected 0/0/0", stat_lookups, stat_hits, stat_mispredicts);
    end
    tick();
    rst = 1'b0;
    driveUpdate(32'h80, 32'h777, 1'b1, 1'b0, 1'b0);
    cnt = 0;
    foundInInit = 0;
    @(negedge clk);
    for (int i = 0; i < 40; i++) begin
      if (ready === 1'b1) break;
      if (BTB_found !== 1'b0) foundInInit++;
      cnt++;
      @(negedge clk);
    end
    clearUpdate();
    lookup_valid = 1'b0;
    checks++;
    if (cnt != 16) begin errors++; $display("[TB] FAIL init_len: got %0d cycles, expected 16", cnt); end
    checks++;
    if (foundInInit != 0) begin errors++; $display("[TB] FAIL init_found: got %0d hits, expected 0", foundInInit); end
    tick();
    pushLookup(32'h40, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    expL = sbQ.pop_front();
    checks++;
    if (BTB_found !== expL.found) begin errors++; $display("[TB] FAIL post_init_40: got %0b, expected %0b", BTB_found, expL.found); end
    tick();
    pushLookup(32'h80, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    expL = sbQ.pop_front();
    checks++;
    if (BTB_found !== expL.found) begin errors++; $display("[TB] FAIL init_upd_ignored: got %0b, expected %0b", BTB_found, expL.found); end
    tick();
    lookup_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    driveUpdate(32'h80, 32'h500, 1'b1, 1'b0, 1'b0);
    pushLookup(32'h80, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    expL = sbQ.pop_front();
    checks++;
    if (BTB_found !== expL.found) begin errors++; $display("[TB] FAIL same_cycle_found: got %0b, expected %0b", BTB_found, expL.found); end
    tick();
    clearUpdate();
    pushLookup(32'h80, 1'b1, 1'b1, 32'h500);
    @(negedge clk);
    expL = sbQ.pop_front();
    checks++;
    if (BTB_found !== expL.found) begin errors++; $display("[TB] FAIL next_cycle_found: got %0b, expected %0b", BTB_found, expL.found); end
    checks++;
    if (predict_target !== expL.target) begin errors++; $display("[TB] FAIL next_cycle_target: got %0h, expected %0h", predict_target, expL.target); end
    tick();
    lookup_valid = 1'b0;
  endtask

  task automatic test_alloc();
    applyUpdate(32'h40, 32'h100, 1'b1, 1'b0, 1'b0);
    pushLookup(32'h40, 1'b1, 1'b1, 32'h100);
    @(negedge clk);
    expL = sbQ.pop_front();
    checks++;
    if ({BTB_found, predict_result} !== {expL.found, expL.pred}) begin
      errors++;
      $display("[TB] FAIL alloc_hit: got found=%0b pred=%0b, expected found=%0b pred=%0b", BTB_found, predict_result, expL.found, expL.pred);
    end
    checks++;
    if (predict_target !== expL.target) begin errors++; $display("[TB] FAIL alloc_target: got %0h, expected %0h", predict_target, expL.target); end
    tick();
    lookup_valid = 1'b0;
  endtask

  task automatic test_counter();
    logic        taken [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] tgt   [9] = '{32'h999C, 32'h999C, 32'h999C, 32'h100, 32'h100, 32'h100, 32'h100, 32'h140, 32'h777C};
    logic        pred  [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [31:0] etgt  [9] = '{32'h100, 32'h100, 32'h100, 32'h100, 32'h100, 32'h100, 32'h100, 32'h140, 32'h140};
    for (int s = 0; s < 9; s++) begin
      applyUpdate(32'h40, tgt[s], taken[s], 1'b0, 1'b0);
      pushLookup(32'h40, 1'b1, pred[s], etgt[s]);
      @(negedge clk);
      expL = sbQ.pop_front();
      checks++;
      if ({BTB_found, predict_result} !== {expL.found, expL.pred}) begin
        errors++;
        $display("[TB] FAIL ctr_step%0d: got found=%0b pred=%0b, expected found=%0b pred=%0b", s, BTB_found, predict_result, expL.found, expL.pred);
      end
      checks++;
      if (predict_target !== expL.target) begin errors++; $display("[TB] FAIL ctr_target%0d: got %0h, expected %0h", s, predict_target, expL.target); end
      tick();
      lookup_valid = 1'b0;
    end
  endtask

  task automatic test_alias();
    applyUpdate(32'h440, 32'h200, 1'b1, 1'b0, 1'b0);
    pushLookup(32'h40, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    expL = sbQ.pop_front();
    checks++;
    if (BTB_found !== expL.found) begin errors++; $display("[TB] FAIL alias_old: got %0b, expected %0b", BTB_found, expL.found); end
    tick();
    pushLookup(32'h440, 1'b1, 1'b1, 32'h200);
    @(negedge clk);
    expL = sbQ.pop_front();
    checks++;
    if ({BTB_found, predict_result} !== {expL.found, expL.pred}) begin
      errors++;
      $display("[TB] FAIL alias_new: got found=%0b pred=%0b, expected found=%0b pred=%0b", BTB_found, predict_result, expL.found, expL.pred);
    end
    checks++;
    if (predict_target !== expL.target) begin errors++; $display("[TB] FAIL alias_target: got %0h, expected %0h", predict_target, expL.target); end
    tick();
    lookup_valid = 1'b0;
  endtask

  task automatic test_uncond();
    applyUpdate(32'h10, 32'h300, 1'b1, 1'b1, 1'b0);
    applyUpdate(32'h10, 32'h0, 1'b0, 1'b1, 1'b0);
    pushLookup(32'h10, 1'b1, 1'b1, 32'h300);
    @(negedge clk);
    expL = sbQ.pop_front();
    checks++;
    if ({BTB_found, predict_result} !== {expL.found, expL.pred}) begin
      errors++;
      $display("[TB] FAIL uncond_strong: got found=%0b pred=%0b, expected found=%0b pred=%0b", BTB_found, predict_result, expL.found, expL.pred);
    end
    checks++;
    if (predict_target !== expL.target) begin errors++; $display("[TB] FAIL uncond_target: got %0h, expected %0h", predict_target, expL.target); end
    tick();
    lookup_valid = 1'b0;
    applyUpdate(32'h24, 32'h600, 1'b0, 1'b0, 1'b0);
    pushLookup(32'h24, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    expL = sbQ.pop_front();
    checks++;
    if (BTB_found !== expL.found) begin errors++; $display("[TB] FAIL miss_not_taken: got %0b, expected %0b", BTB_found, expL.found); end
    tick();
    lookup_valid = 1'b0;
  endtask

  task automatic test_stats();
    logic [31:0] pcs [4]  = '{32'h40, 32'h44, 32'h48, 32'h4C};
    logic        hit [4]  = '{1'b1, 1'b1, 1'b1, 1'b0};
    int cnt;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 40 && ready !== 1'b1; i++) tick();
    for (int i = 0; i < 3; i++) applyUpdate(pcs[i], 32'h1000 + 32'(i), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      pushLookup(pcs[i], hit[i], hit[i], 32'h1000 + 32'(i));
      @(negedge clk);
      expL = sbQ.pop_front();
      checks++;
      if (BTB_found !== expL.found) begin errors++; $display("[TB] FAIL stats_lookup%0d: got %0b, expected %0b", i, BTB_found, expL.found); end
      tick();
      lookup_valid = 1'b0;
    end
    applyUpdate(32'h40, 32'h1000, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    checks++;
    if ({stat_lookups, stat_hits, stat_mispredicts} !== {EXP_LOOKUPS, EXP_HITS, EXP_MISP}) begin
      errors++;
      $display("[TB] FAIL stats_values: got %0d/%0d/%0d, expected %0d/%0d/%0d", stat_lookups, stat_hits, stat_mispredicts, EXP_LOOKUPS, EXP_HITS, EXP_MISP);
    end
    tick();
    rst = 1'b1;
    pushLookup(32'h40, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    expL = sbQ.pop_front();
    checks++;
    if (BTB_found !== expL.found) begin errors++; $display("[TB] FAIL rst_cycle_found: got %0b, expected %0b", BTB_found, expL.found); end
    tick();
    rst = 1'b0;
    lookup_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({stat_lookups, stat_hits, stat_mispredicts} !== 96'd0) begin
      errors++;
      $display("[TB] FAIL midrun_stats: got %0h/%0h/%0h, expected 0/0/0", stat_lookups, stat_hits, stat_mispredicts);
    end
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (ready === 1'b1) break;
      cnt++;
      @(negedge clk);
    end
    checks++;
    if (cnt != 16) begin errors++; $display("[TB] FAIL midrun_init_len: got %0d cycles, expected 16", cnt); end
    tick();
    pushLookup(32'h40, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    expL = sbQ.pop_front();
    checks++;
    if (BTB_found !== expL.found) begin errors++; $display("[TB] FAIL midrun_flushed: got %0b, expected %0b", BTB_found, expL.found); end
    tick();
    lookup_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst          = 1'b1;
    lookup_valid = 1'b0;
    lookup_pc    = 32'h0;
    upd_pc       = 32'h0;
    upd_target   = 32'h0;
    clearUpdate();
    test_reset();
    test_back_to_back();
    test_alloc();
    test_counter();
    test_alias();
    test_uncond();
    test_stats();
    checks++;
    if (sbQ.size() != 0) begin errors++; $display("[TB] FAIL scoreboard_drain: got %0d left, expected 0", sbQ.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
